// File: rtl/ball_physics.sv
// Pong ball kinematics: serve delay, wall and paddle bounces, goals, scoring and
// a registered per-pixel ball hit flag for the video path.
module ball_physics #(
    parameter int unsigned SCREEN_W     = 640,
    parameter int unsigned SCREEN_H     = 480,
    parameter int unsigned BALL_SIZE    = 8,
    parameter int unsigned SPEED        = 2,
    parameter int unsigned P1_X         = 50,
    parameter int unsigned P2_X         = 590,
    parameter int unsigned PADDLE_W     = 10,
    parameter int unsigned PADDLE_H     = 80,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned WIN_SCORE    = 9
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic [9:0] hsp,
    input  logic [9:0] vsp,
    input  logic [9:0] p1_y,
    input  logic [9:0] p2_y,
    input  logic       start,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       ball_intersect,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       game_over
);

    typedef enum logic [1:0] {SERVE, PLAY, GAME_OVER} state_t;

    localparam int unsigned CNT_W  = $clog2(SERVE_FRAMES + 1);
    localparam logic [9:0]  X_CTR  = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [9:0]  Y_CTR  = 10'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [10:0] BSZ    = 11'(BALL_SIZE);
    localparam logic [10:0] SPD    = 11'(SPEED);
    localparam logic [10:0] PAD_H  = 11'(PADDLE_H);
    localparam logic [10:0] L_EDGE = 11'(P1_X + PADDLE_W);
    localparam logic [10:0] R_EDGE = 11'(P2_X);
    localparam logic [10:0] X_LIM  = 11'(SCREEN_W);
    localparam logic [10:0] Y_MAX  = 11'(SCREEN_H - BALL_SIZE);
    localparam logic [3:0]  WIN4   = 4'(WIN_SCORE);

    state_t           state;
    logic [CNT_W-1:0] serve_cnt;
    logic             dx_neg;
    logic             dy_neg;

    logic [10:0] x11, y11, p1_11, p2_11, h11, v11;
    logic        ov1, ov2, hit_l, hit_r, goal_l, goal_r;
    logic [9:0]  x_move, y_move;
    logic        dy_neg_move;
    logic [3:0]  s1_inc, s2_inc;
    logic        pix_in;

    always_comb begin
        x11   = {1'b0, ball_x};
        y11   = {1'b0, ball_y};
        p1_11 = {1'b0, p1_y};
        p2_11 = {1'b0, p2_y};
        h11   = {1'b0, hsp};
        v11   = {1'b0, vsp};

        ov1 = (y11 < p1_11 + PAD_H) && (p1_11 < y11 + BSZ);
        ov2 = (y11 < p2_11 + PAD_H) && (p2_11 < y11 + BSZ);

        // x - SPEED < edge is rewritten as x < edge + SPEED so nothing underflows
        hit_l  = dx_neg && (x11 >= L_EDGE) && (x11 < L_EDGE + SPD) && ov1;
        hit_r  = !dx_neg && (x11 + BSZ <= R_EDGE) && (x11 + BSZ + SPD > R_EDGE) && ov2;
        goal_l = dx_neg && (x11 < SPD) && !hit_l;
        goal_r = !dx_neg && (x11 + BSZ + SPD > X_LIM) && !hit_r;

        if (hit_l)
            x_move = 10'(L_EDGE);
        else if (hit_r)
            x_move = 10'(R_EDGE - BSZ);
        else if (dx_neg)
            x_move = 10'(x11 - SPD);
        else
            x_move = 10'(x11 + SPD);

        dy_neg_move = dy_neg;
        if (dy_neg && (y11 < SPD)) begin
            y_move      = '0;
            dy_neg_move = 1'b0;
        end else if (!dy_neg && (y11 + SPD > Y_MAX)) begin
            y_move      = 10'(Y_MAX);
            dy_neg_move = 1'b1;
        end else if (dy_neg) begin
            y_move = 10'(y11 - SPD);
        end else begin
            y_move = 10'(y11 + SPD);
        end

        s1_inc = (score1 < WIN4) ? score1 + 4'd1 : score1;
        s2_inc = (score2 < WIN4) ? score2 + 4'd1 : score2;

        pix_in = (hsp >= ball_x) && (h11 < x11 + BSZ) &&
                 (vsp >= ball_y) && (v11 < y11 + BSZ);
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= SERVE;
            serve_cnt      <= '0;
            ball_x         <= X_CTR;
            ball_y         <= Y_CTR;
            dx_neg         <= 1'b0;
            dy_neg         <= 1'b0;
            score1         <= '0;
            score2         <= '0;
            ball_intersect <= 1'b0;
            game_over      <= 1'b0;
        end else begin
            ball_intersect <= pix_in && (state != GAME_OVER);
            if (frame_tick) begin
                case (state)
                    SERVE: begin
                        ball_x <= X_CTR;
                        ball_y <= Y_CTR;
                        if (serve_cnt == CNT_W'(SERVE_FRAMES - 1)) begin
                            serve_cnt <= '0;
                            state     <= PLAY;
                        end else begin
                            serve_cnt <= serve_cnt + CNT_W'(1);
                        end
                    end
                    PLAY: begin
                        if (goal_l || goal_r) begin
                            // ball re-centres immediately and heads at whoever conceded
                            ball_x <= X_CTR;
                            ball_y <= Y_CTR;
                            dx_neg <= goal_l;
                            dy_neg <= 1'b0;
                            if (goal_l) begin
                                score2 <= s2_inc;
                                if (s2_inc == WIN4) begin
                                    state     <= GAME_OVER;
                                    game_over <= 1'b1;
                                end else begin
                                    state <= SERVE;
                                end
                            end else begin
                                score1 <= s1_inc;
                                if (s1_inc == WIN4) begin
                                    state     <= GAME_OVER;
                                    game_over <= 1'b1;
                                end else begin
                                    state <= SERVE;
                                end
                            end
                        end else begin
                            ball_x <= x_move;
                            ball_y <= y_move;
                            dy_neg <= dy_neg_move;
                            if (hit_l)
                                dx_neg <= 1'b0;
                            else if (hit_r)
                                dx_neg <= 1'b1;
                        end
                    end
                    GAME_OVER: begin
                        if (start) begin
                            score1    <= '0;
                            score2    <= '0;
                            dx_neg    <= 1'b0;
                            dy_neg    <= 1'b0;
                            ball_x    <= X_CTR;
                            ball_y    <= Y_CTR;
                            serve_cnt <= '0;
                            game_over <= 1'b0;
                            state     <= SERVE;
                        end
                    end
                    default: state <= SERVE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ball_physics.sv
// Randomized bench for ball_physics: paddles driven from a rule-level game model,
// every frame and many pixels checked against that model.
module tb_ball_physics;

    localparam int SW = 640, SH = 480, BS = 8, SPD = 2;
    localparam int P1X = 50, P2X = 590, PW = 10, PH = 80;
    localparam int SF = 60, WIN = 9;
    localparam int XC = (SW - BS) / 2, YC = (SH - BS) / 2;
    localparam int M_SERVE = 0, M_PLAY = 1, M_OVER = 2;

    logic       vga_clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic [9:0] hsp = '0, vsp = '0, p1_y = '0, p2_y = '0;
    logic [9:0] ball_x, ball_y;
    logic       ball_intersect, game_over;
    logic [3:0] score1, score2;

    always #5 vga_clk = ~vga_clk;

    ball_physics #(
        .SCREEN_W(SW), .SCREEN_H(SH), .BALL_SIZE(BS), .SPEED(SPD),
        .P1_X(P1X), .P2_X(P2X), .PADDLE_W(PW), .PADDLE_H(PH),
        .SERVE_FRAMES(SF), .WIN_SCORE(WIN)
    ) dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .frame_tick(frame_tick),
        .hsp(hsp), .vsp(vsp), .p1_y(p1_y), .p2_y(p2_y), .start(start),
        .ball_x(ball_x), .ball_y(ball_y), .ball_intersect(ball_intersect),
        .score1(score1), .score2(score2), .game_over(game_over)
    );

    int n_cmp = 0, n_err = 0;
    int n_hit = 0, n_wall = 0, n_goal = 0;
    int m_st, m_cnt, m_x, m_y, m_dx, m_dy, m_s1, m_s2;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_st = M_SERVE; m_cnt = 0; m_x = XC; m_y = YC;
        m_dx = 1; m_dy = 1; m_s1 = 0; m_s2 = 0;
    endfunction

    function automatic void model_tick(input int p1, input int p2, input bit st);
        bit ov1, ov2, goal, won;
        int ny;
        goal = 0; won = 0;
        if (m_st == M_SERVE) begin
            m_cnt++;
            if (m_cnt == SF) begin
                m_cnt = 0;
                m_st  = M_PLAY;
            end
        end else if (m_st == M_PLAY) begin
            ov1 = (m_y < p1 + PH) && (p1 < m_y + BS);
            ov2 = (m_y < p2 + PH) && (p2 < m_y + BS);
            if (m_dx < 0 && m_x >= P1X + PW && m_x - SPD < P1X + PW && ov1) begin
                m_x = P1X + PW; m_dx = 1; n_hit++;
            end else if (m_dx > 0 && m_x + BS <= P2X && m_x + BS + SPD > P2X && ov2) begin
                m_x = P2X - BS; m_dx = -1; n_hit++;
            end else if (m_dx < 0 && m_x < SPD) begin
                if (m_s2 < WIN) m_s2++;
                goal = 1; won = (m_s2 == WIN); m_dx = -1;
            end else if (m_dx > 0 && m_x + BS + SPD > SW) begin
                if (m_s1 < WIN) m_s1++;
                goal = 1; won = (m_s1 == WIN); m_dx = 1;
            end else begin
                m_x = m_x + m_dx * SPD;
            end
            if (goal) begin
                n_goal++;
                m_dy = 1; m_x = XC; m_y = YC;
                m_st = won ? M_OVER : M_SERVE;
            end else begin
                ny = m_y + m_dy * SPD;
                if (ny < 0) begin
                    m_y = 0; m_dy = 1; n_wall++;
                end else if (ny > SH - BS) begin
                    m_y = SH - BS; m_dy = -1; n_wall++;
                end else begin
                    m_y = ny;
                end
            end
        end else if (st) begin
            m_s1 = 0; m_s2 = 0; m_dx = 1; m_dy = 1;
            m_x = XC; m_y = YC; m_st = M_SERVE;
        end
    endfunction

    task automatic do_tick(input int p1, input int p2, input bit st);
        p1_y = 10'(p1); p2_y = 10'(p2); start = st;
        frame_tick = 1'b1;
        @(posedge vga_clk); #1;
        frame_tick = 1'b0;
        model_tick(p1, p2, st);
        check_eq("ball_x", 32'(ball_x), m_x);
        check_eq("ball_y", 32'(ball_y), m_y);
        check_eq("score1", 32'(score1), m_s1);
        check_eq("score2", 32'(score2), m_s2);
        check_eq("game_over", 32'(game_over), 32'(m_st == M_OVER));
    endtask

    task automatic idle_check();
        int h, v;
        bit exp;
        if ($urandom_range(0, 1) == 1) begin
            h = m_x + $urandom_range(0, BS + 1) - 1;
            v = m_y + $urandom_range(0, BS + 1) - 1;
            if (h < 0) h = 0;
            if (v < 0) v = 0;
        end else begin
            h = $urandom_range(0, 1023);
            v = $urandom_range(0, 1023);
        end
        hsp = 10'(h); vsp = 10'(v);
        @(posedge vga_clk); #1;
        exp = (m_st != M_OVER) && h >= m_x && h < m_x + BS && v >= m_y && v < m_y + BS;
        check_eq("ball_intersect", 32'(ball_intersect), 32'(exp));
    endtask

    function automatic int paddle_pos(input int track_pct);
        int p;
        if ($urandom_range(0, 99) < track_pct) begin
            p = m_y - $urandom_range(0, PH - 1);
            if (p < 0) p = 0;
        end else begin
            p = $urandom_range(0, SH - PH);
        end
        return p;
    endfunction

    task automatic play_tick(input bit allow_start);
        int p1, p2;
        bit st;
        p1 = paddle_pos(50);
        p2 = paddle_pos(20);
        st = allow_start ? bit'($urandom_range(0, 1)) : 1'b0;
        do_tick(p1, p2, st);
        idle_check();
    endtask

    task automatic pixel_probe(input int h, input int v, input bit exp, input string tag);
        hsp = 10'(h); vsp = 10'(v);
        @(posedge vga_clk); #1;
        check_eq(tag, 32'(ball_intersect), 32'(exp));
    endtask

    task automatic check_reset_values();
        check_eq("rst_ball_x", 32'(ball_x), 316);
        check_eq("rst_ball_y", 32'(ball_y), 236);
        check_eq("rst_score1", 32'(score1), 0);
        check_eq("rst_score2", 32'(score2), 0);
        check_eq("rst_game_over", 32'(game_over), 0);
        check_eq("rst_intersect", 32'(ball_intersect), 0);
    endtask

    task automatic serve_sequence();
        for (int i = 1; i <= SF + 1; i++) begin
            do_tick($urandom_range(0, SH - PH), $urandom_range(0, SH - PH), 1'b0);
            if (i <= SF) idle_check();
        end
        check_eq("serve_x_tick61", 32'(ball_x), 318);
        check_eq("serve_y_tick61", 32'(ball_y), 238);
    endtask

    initial begin
        int budget;
        model_reset();
        #1 reset_n = 1'b0;
        #1 check_reset_values();
        repeat (2) @(posedge vga_clk);
        @(negedge vga_clk) reset_n = 1'b1;
        @(posedge vga_clk); #1;

        pixel_probe(316, 236, 1'b1, "pix_corner");
        pixel_probe(323, 243, 1'b1, "pix_far_corner");
        pixel_probe(324, 236, 1'b0, "pix_right_out");
        pixel_probe(316, 244, 1'b0, "pix_below_out");

        serve_sequence();

        budget = 0;
        while (m_st != M_OVER && budget < 30000) begin
            play_tick(1'b1);
            budget++;
        end
        check_eq("game_over_reached", 32'(game_over), 1);

        for (int i = 0; i < 3; i++) begin
            do_tick($urandom_range(0, SH - PH), $urandom_range(0, SH - PH), 1'b0);
            idle_check();
            pixel_probe(m_x, m_y, 1'b0, "pix_in_game_over");
        end
        do_tick(200, 200, 1'b1);
        check_eq("restart_score1", 32'(score1), 0);
        check_eq("restart_score2", 32'(score2), 0);
        check_eq("restart_game_over", 32'(game_over), 0);

        for (int i = 0; i < 200; i++) play_tick(1'b1);

        #2 reset_n = 1'b0;
        #1 check_reset_values();
        model_reset();
        @(negedge vga_clk) reset_n = 1'b1;
        @(posedge vga_clk); #1;
        serve_sequence();
        for (int i = 0; i < 100; i++) play_tick(1'b1);

        $display("events: paddle_hits=%0d wall_bounces=%0d goals=%0d", n_hit, n_wall, n_goal);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ball_physics.md
BALL_PHYSICS -- requirements
Module: ball_physics

Interface
REQ-001 Parameter SCREEN_W, default 640, active pixel columns.
REQ-002 Parameter SCREEN_H, default 480, active pixel rows.
REQ-003 Parameter BALL_SIZE, default 8, ball edge length in pixels.
REQ-004 Parameter SPEED, default 2, pixels moved per axis per frame.
REQ-005 Parameter P1_X, default 50, left paddle left edge; P2_X, default 590, right paddle left edge.
REQ-006 Parameter PADDLE_W, default 10, and PADDLE_H, default 80, paddle width and height.
REQ-007 Parameter SERVE_FRAMES, default 60, serve delay in frames; WIN_SCORE, default 9, winning score.
REQ-008 vga_clk  input  1  pixel clock, the only clock; all state updates on its rising edge.
REQ-009 reset_n  input  1  asynchronous, active-low reset.
REQ-010 frame_tick  input  1  one-cycle pulse per frame, at start of vertical blanking.
REQ-011 hsp, vsp  input  10 each  current pixel column and row from the sync generator.
REQ-012 p1_y, p2_y  input  10 each  top row of the left and right paddles.
REQ-013 start  input  1  restart request, level-sampled on frame_tick.
REQ-014 ball_x, ball_y  output  10 each  ball top-left corner.
REQ-015 ball_intersect  output  1  registered flag: current pixel lies inside the ball.
REQ-016 score1, score2  output  4 each  left and right player scores.
REQ-017 game_over  output  1  high while in GAME_OVER state.

Function
REQ-018 The FSM SHALL have exactly three states: SERVE, PLAY and GAME_OVER; all transitions occur only in cycles where frame_tick=1.
REQ-019 In SERVE: ball held at ((SCREEN_W-BALL_SIZE)/2, (SCREEN_H-BALL_SIZE)/2); the serve counter increments per tick; after SERVE_FRAMES ticks, clear the counter and go to PLAY.
REQ-020 Direction registers dx, dy each hold +1 or -1; movement is SPEED pixels per tick per axis, PLAY state only.
REQ-021 Vertical: if dy=-1 and y<SPEED, set y=0, dy=+1; if dy=+1 and y+SPEED>SCREEN_H-BALL_SIZE, set y=SCREEN_H-BALL_SIZE, dy=-1; otherwise y=y+dy*SPEED.
REQ-022 Paddle overlap means ball rows [y, y+BALL_SIZE) intersect paddle rows [p_y, p_y+PADDLE_H); overlap uses the pre-update y.
REQ-023 Left hit: if dx=-1, x>=P1_X+PADDLE_W, x-SPEED<P1_X+PADDLE_W and left overlap, set x=P1_X+PADDLE_W, dx=+1.
REQ-024 Right hit: if dx=+1, x+BALL_SIZE<=P2_X, x+BALL_SIZE+SPEED>P2_X and right overlap, set x=P2_X-BALL_SIZE, dx=-1.
REQ-025 Goal: if dx=-1 and x<SPEED, score2 increments; if dx=+1 and x+BALL_SIZE+SPEED>SCREEN_W, score1 increments; otherwise x=x+dx*SPEED.
REQ-026 Goal priority: a paddle hit in the same tick suppresses the goal; a goal suppresses the vertical update for that tick.
REQ-027 After a goal: dx points toward the conceding player, dy=+1; go to GAME_OVER if the incremented score equals WIN_SCORE, else to SERVE.
REQ-028 Scores never exceed WIN_SCORE; no wrap-around.
REQ-029 In GAME_OVER: position and scores frozen; start=1 on a tick clears both scores, sets dx=+1, dy=+1, goes to SERVE.
REQ-030 ball_intersect SHALL be registered (1-cycle latency from hsp/vsp): 1 iff ball_x<=hsp<ball_x+BALL_SIZE and ball_y<=vsp<ball_y+BALL_SIZE and state is not GAME_OVER.
REQ-031 All arithmetic uses at least 11-bit unsigned intermediates; no intermediate wraps.

Reset
REQ-032 reset_n=0 SHALL asynchronously force: state=SERVE, serve counter=0, ball_x=316, ball_y=236, dx=+1, dy=+1, score1=score2=0, ball_intersect=0, game_over=0.
REQ-033 Reset asserted mid-PLAY or mid-GAME_OVER SHALL discard all in-flight state; after release, the first move occurs on the 61st tick.

Verification
REQ-034 Serve: release reset, issue 61 ticks -> ball_x=318, ball_y=238 after tick 61; ball static before that.
REQ-035 Top wall: PLAY, y=1, dy=-1, one tick -> y=0, dy=+1.
REQ-036 Left paddle: x=61, dx=-1, y=100, p1_y=90, one tick -> x=60, dx=+1, scores unchanged.
REQ-037 Miss: x=1, dx=-1, p1_y=300, y=100, one tick -> score2=1, state=SERVE, ball centred, dx=-1.
REQ-038 Win and restart: score1=8, right goal -> score1=9, game_over=1, ball_intersect=0 everywhere; start=1 on next tick -> scores 0, SERVE.
REQ-039 Intersect: ball at (316,236); hsp=316, vsp=236 -> ball_intersect=1 one cycle later; hsp=324 -> 0.
